// File: rtl/label_window_buffer.sv
// ============================================================================
// label_window_buffer
// ----------------------------------------------------------------------------
// Neighbourhood generator that sits directly upstream of the CCL labeler and
// closes its feedback loop. Each pixel's final label arrives in raster order.
// The previous image row is kept in a line buffer. For the next pixel the
// block presents the causal window:
//     A (up-left)  B (up)  C (up-right)
//     D (left)     [current pixel]
// It also owns the raster counters x/y that the labeler consumes.
//
// Optional feature (compile-time macro):
//   LABEL_WINDOW_SOF_EN - adds the 'sof' input for frame resynchronisation.
//                         When it is undefined, the counters resync only
//                         through reset_n.
//
// Parameters:
//   WIDTH      pixels per row (>= 3)
//   HEIGHT     rows per frame (>= 2)
//   WORD_SIZE  label width in bits; label 0 is background
//
// Ports:
//   clk         clock
//   reset_n     synchronous, active-low reset
//   en          advance: label_in is the label of pixel (x,y)
//   label_in    final label of the current pixel
//   A,B,C,D     registered neighbour labels of pixel (x,y)
//   x, y        current column / row
//   frame_done  1-cycle pulse after the last pixel of a frame is accepted
//   sof         frame resync (only with LABEL_WINDOW_SOF_EN)
// ============================================================================
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

module label_window_buffer #(
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480,
    parameter int WORD_SIZE = `WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic [WORD_SIZE-1:0] label_in,
    output logic [WORD_SIZE-1:0] A,
    output logic [WORD_SIZE-1:0] B,
    output logic [WORD_SIZE-1:0] C,
    output logic [WORD_SIZE-1:0] D,
    output logic [31:0]          x,
    output logic [31:0]          y,
    output logic                 frame_done
`ifdef LABEL_WINDOW_SOF_EN
    ,
    input  logic                 sof
`endif
);

    localparam int          AW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [31:0] X_LAST = 32'(WIDTH - 1);
    localparam logic [31:0] Y_LAST = 32'(HEIGHT - 1);

    // Previous-row labels; contents after reset are don't-care because the
    // top-border gating hides them until row 0 has been fully rewritten.
    logic [WORD_SIZE-1:0] linebuf [WIDTH];

    // Raw window shift registers (before top-border gating).
    logic [WORD_SIZE-1:0] a_q, b_q, c_q, d_q;

    logic                 row_end;
    logic                 frame_end;
    logic [31:0]          x_plus2;
    logic [AW-1:0]        rd_idx;
    logic [AW-1:0]        wr_idx;
    logic [WORD_SIZE-1:0] c_next;
    logic                 sof_go;

`ifdef LABEL_WINDOW_SOF_EN
    assign sof_go = sof;
`else
    assign sof_go = 1'b0;
`endif

    // Next-C lookahead: the column two ahead of the current one, or zero
    // past the right border. The write address is x itself, so the read at
    // x+2 (or 0/1 on a wrap, with x = WIDTH-1 >= 2) never aliases it.
    always_comb begin
        row_end   = (x == X_LAST);
        frame_end = row_end && (y == Y_LAST);
        x_plus2   = x + 32'd2;
        rd_idx    = x_plus2[AW-1:0];
        c_next    = '0;
        if (x_plus2 <= X_LAST) begin
            c_next = linebuf[rd_idx];
        end
        // A resync pixel is always pixel (0,0) of the new frame.
        wr_idx = sof_go ? '0 : x[AW-1:0];
    end

    // Line buffer write: the old value at this column already lives in the
    // B shift register, so overwriting it with the new row is safe.
    always_ff @(posedge clk) begin
        if (reset_n && en) begin
            linebuf[wr_idx] <= label_in;
        end
    end

    // Raster counters and window shift registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x          <= '0;
            y          <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            d_q        <= '0;
            frame_done <= 1'b0;
        end
`ifdef LABEL_WINDOW_SOF_EN
        else if (sof) begin
            // Abandon any partial frame without a frame_done pulse.
            y          <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            frame_done <= 1'b0;
            if (en) begin
                x   <= 32'd1;
                d_q <= label_in;
            end else begin
                x   <= '0;
                d_q <= '0;
            end
        end
`endif
        else if (!en) begin
            frame_done <= 1'b0;
        end else if (row_end) begin
            // Reload B/C from columns 0/1 of the row just completed.
            x   <= '0;
            a_q <= '0;
            b_q <= linebuf[0];
            c_q <= linebuf[1];
            d_q <= '0;
            if (frame_end) begin
                y          <= '0;
                frame_done <= 1'b1;
            end else begin
                y          <= y + 32'd1;
                frame_done <= 1'b0;
            end
        end else begin
            x          <= x + 32'd1;
            a_q        <= b_q;
            b_q        <= c_q;
            c_q        <= c_next;
            d_q        <= label_in;
            frame_done <= 1'b0;
        end
    end

    // Row 0 has no row above it, so the upper window is forced to zero.
    assign A = (y == 32'd0) ? '0 : a_q;
    assign B = (y == 32'd0) ? '0 : b_q;
    assign C = (y == 32'd0) ? '0 : c_q;
    assign D = d_q;

endmodule

// File: tb/tb_label_window_buffer.sv
// ============================================================================
// tb_label_window_buffer
// ----------------------------------------------------------------------------
// Scoreboard bench for label_window_buffer (WIDTH=4, HEIGHT=3, WORD_SIZE=8).
// The stimulus process drives one cycle at a time, advances a frame-image
// reference model and pushes the expected window into a queue. A separate
// monitor pops one entry after every rising edge and compares it.
// ============================================================================
module tb_label_window_buffer;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int WS = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          en = 1'b0;
    logic [WS-1:0] label_in = '0;
    logic [WS-1:0] A, B, C, D;
    logic [31:0]   x, y;
    logic          frame_done;
`ifdef LABEL_WINDOW_SOF_EN
    logic          sof = 1'b0;
`endif

    label_window_buffer #(
        .WIDTH(W), .HEIGHT(H), .WORD_SIZE(WS)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .label_in  (label_in),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .x         (x),
        .y         (y),
        .frame_done(frame_done)
`ifdef LABEL_WINDOW_SOF_EN
        ,
        .sof       (sof)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WS-1:0] a, b, c, d;
        int            px, py;
        logic          fd;
    } exp_t;

    exp_t expQ[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: the current frame as a 2-D image plus the raster
    // position of the next pixel.
    logic [WS-1:0] img [H][W];
    int            mx = 0;
    int            my = 0;
    logic          mfd = 1'b0;

    function automatic exp_t modelWindow();
        exp_t e;
        e.px = mx;
        e.py = my;
        e.fd = mfd;
        e.a  = '0;
        e.b  = '0;
        e.c  = '0;
        e.d  = '0;
        if (my > 0) begin
            if (mx > 0)     e.a = img[my-1][mx-1];
            e.b = img[my-1][mx];
            if (mx < W - 1) e.c = img[my-1][mx+1];
        end
        if (mx > 0) e.d = img[my][mx-1];
        return e;
    endfunction

    task automatic applyReset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset_n = 1'b0;
            en      = 1'b0;
`ifdef LABEL_WINDOW_SOF_EN
            sof     = 1'b0;
`endif
            mx  = 0;
            my  = 0;
            mfd = 1'b0;
            expQ.push_back(modelWindow());
        end
    endtask

    task automatic applyStimulus(input logic e, input logic [WS-1:0] lbl, input logic s);
        @(negedge clk);
        reset_n  = 1'b1;
        en       = e;
        label_in = lbl;
        mfd      = 1'b0;
`ifdef LABEL_WINDOW_SOF_EN
        sof = s;
        if (s) begin
            if (e) begin
                img[0][0] = lbl;
                mx = 1;
            end else begin
                mx = 0;
            end
            my = 0;
        end else
`endif
        if (e) begin
            img[my][mx] = lbl;
            if (mx == W - 1) begin
                mx = 0;
                if (my == H - 1) begin
                    my  = 0;
                    mfd = 1'b1;
                end else begin
                    my++;
                end
            end else begin
                mx++;
            end
        end
        if (s && !e) mfd = 1'b0;
        expQ.push_back(modelWindow());
    endtask

    task automatic checkOutput(input exp_t e);
        tests++;
        if (A !== e.a || B !== e.b || C !== e.c || D !== e.d ||
            x !== 32'(e.px) || y !== 32'(e.py) || frame_done !== e.fd) begin
            fails++;
            $display("[TB] FAIL window: got A=%0d B=%0d C=%0d D=%0d x=%0d y=%0d fd=%0b, expected A=%0d B=%0d C=%0d D=%0d x=%0d y=%0d fd=%0b",
                     A, B, C, D, x, y, frame_done,
                     e.a, e.b, e.c, e.d, e.px, e.py, e.fd);
        end
    endtask

    // Monitor: one expectation per clock edge, sampled 1 time unit later.
    always @(posedge clk) begin
        #1;
        if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end

    // Watchdog so the bench always ends.
    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = '0;

        // Reset followed by idle cycles.
        applyReset(3);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'd0, 1'b0);

        // Directed frame: labels 1..12, then row 0 of the next frame.
        for (int i = 1; i <= 12; i++) applyStimulus(1'b1, 8'(i), 1'b0);
        for (int i = 13; i <= 16; i++) applyStimulus(1'b1, 8'(i), 1'b0);

        // Gaps inserted mid-row.
        applyStimulus(1'b1, 8'd20, 1'b0);
        applyStimulus(1'b0, 8'd99, 1'b0);
        applyStimulus(1'b0, 8'd98, 1'b0);
        applyStimulus(1'b1, 8'd21, 1'b0);

`ifdef LABEL_WINDOW_SOF_EN
        // Resync at (2,1) with label 9, then resync with en=0.
        applyReset(1);
        for (int i = 1; i <= 6; i++) applyStimulus(1'b1, 8'(i), 1'b0);
        applyStimulus(1'b1, 8'd9, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(30 + i), 1'b0);
        applyStimulus(1'b0, 8'd0, 1'b1);
`endif

        // Randomised traffic with gaps, labels including background 0.
        for (int i = 0; i < 600; i++) begin
            logic          e;
            logic [WS-1:0] l;
            logic          s;
            e = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            s = 1'b0;
`ifdef LABEL_WINDOW_SOF_EN
            s = ($urandom_range(0, 40) == 0);
`endif
            if (i == 300) applyReset(2);
            applyStimulus(e, l, s);
        end

        applyStimulus(1'b0, 8'd0, 1'b0);
        @(posedge clk);
        #2;
        tests++;
        if (expQ.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
